mult_div_unit: RTL

- Parametrised multicycle multiply/divide unit: next generation of the CPU's HI/LO multiplier.
- Adds signed and unsigned multiply and divide, with a `WIDTH`-generic datapath.
- Uses a start/busy/done handshake and reports divide-by-zero.
- Sits beside the ALU: the control unit pulses `start` with operands from registers A/B, waits for `done`, then loads HI/LO from `hi`/`lo`.

---
 rtl/mdu_pkg.sv | 35 +++
 rtl/mdu_magnitude.sv | 19 +
 rtl/mult_div_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types and helpers for the multicycle multiply/divide unit.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents:
//   mdu_op_t    - operation encoding as presented on the op port
//   mdu_state_t - controller states
//   is_signed   - true for the two's-complement operations
//   isDivide    - true for the divide operations
package mdu_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } mdu_op_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    FIX,
    DONE
  } mdu_state_t;

  function automatic logic is_signed(input mdu_op_t opSel);
    return (opSel == MULT) || (opSel == DIV);
  endfunction

  function automatic logic isDivide(input mdu_op_t opSel);
    return (opSel == DIV) || (opSel == DIVU);
  endfunction

endpackage

// File: rtl/mdu_magnitude.sv
// Conditional two's-complement negate; gives |x| for operands and re-applies result signs.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake.
//
// Ports:
//   value  - input word, W bits
//   negate - when high the output is -value (mod 2^W), otherwise value
//   result - output word, W bits
module mdu_magnitude #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed/unsigned multiply and divide producing HI/LO results.
// Latency: WIDTH+3 cycles from the accepted start edge to done; 2 cycles for divide-by-zero.
// Backpressure: start is only sampled in IDLE or DONE; requests while busy are dropped.
//
// Ports:
//   clock, reset        - rising-edge clock, asynchronous active-low reset
//   start, op, a, b     - request and operands, captured together on an accepted start
//   busy                - high while the operation is in LOAD, RUN or FIX
//   done                - one-cycle completion pulse
//   hi, lo              - product high/low halves, or remainder/quotient; held between ops
//   div_zero            - divide with zero divisor seen; cleared by the next accepted start
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  // Iteration counter needs to reach WIDTH-1; never narrower than 5 bits.
  localparam int CntW = ($clog2(WIDTH + 1) > 5) ? $clog2(WIDTH + 1) : 5;

  mdu_state_t         state;
  mdu_op_t            opReg;
  logic [WIDTH-1:0]   aRaw;
  logic [WIDTH-1:0]   bRaw;
  logic [WIDTH-1:0]   operand;      // multiplicand for multiply, divisor for divide
  logic               signA;
  logic               signB;
  logic [2*WIDTH-1:0] acc;          // multiply: {partial, multiplier}; divide: {rem, quo}
  logic [CntW-1:0]    cnt;

  logic               negA;
  logic               negB;
  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic [2*WIDTH-1:0] prodFixed;
  logic [WIDTH-1:0]   quoFixed;
  logic [WIDTH-1:0]   remFixed;

  assign negA = is_signed(opReg) & aRaw[WIDTH-1];
  assign negB = is_signed(opReg) & bRaw[WIDTH-1];

  mdu_magnitude #(.W(WIDTH)) uAbsA (
    .value (aRaw),
    .negate(negA),
    .result(absA)
  );

  mdu_magnitude #(.W(WIDTH)) uAbsB (
    .value (bRaw),
    .negate(negB),
    .result(absB)
  );

  mdu_magnitude #(.W(2*WIDTH)) uProdFix (
    .value (acc),
    .negate(signA ^ signB),
    .result(prodFixed)
  );

  mdu_magnitude #(.W(WIDTH)) uQuoFix (
    .value (acc[WIDTH-1:0]),
    .negate(signA ^ signB),
    .result(quoFixed)
  );

  // The remainder follows the dividend's sign.
  mdu_magnitude #(.W(WIDTH)) uRemFix (
    .value (acc[2*WIDTH-1:WIDTH]),
    .negate(signA),
    .result(remFixed)
  );

  // One iteration of the shift-add multiply or restoring divide.
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     remShift;
  logic               remFits;
  logic [WIDTH-1:0]   remSub;
  logic [2*WIDTH-1:0] accStep;

  always_comb begin
    // Carry out of the upper half is kept and becomes the new MSB after the shift.
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? operand : {WIDTH{1'b0}})};
    // Remainder after shifting {rem, quo} left by one.
    remShift = acc[2*WIDTH-1:WIDTH-1];
    remFits  = (remShift >= {1'b0, operand});
    // A fitting trial difference is always below the divisor, so WIDTH bits suffice.
    remSub   = WIDTH'(remShift - {1'b0, operand});
    if (isDivide(opReg)) begin
      accStep = remFits ? {remSub, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      accStep = {mulSum, acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      opReg    <= MULT;
      aRaw     <= '0;
      bRaw     <= '0;
      operand  <= '0;
      signA    <= 1'b0;
      signB    <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            opReg    <= mdu_op_t'(op);
            aRaw     <= a;
            bRaw     <= b;
            div_zero <= 1'b0;
            busy     <= 1'b1;
            state    <= LOAD;
          end else begin
            state <= IDLE;
          end
        end

        LOAD: begin
          signA <= negA;
          signB <= negB;
          cnt   <= '0;
          if (isDivide(opReg) && (bRaw == '0)) begin
            hi       <= aRaw;
            lo       <= '1;
            div_zero <= 1'b1;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end else if (isDivide(opReg)) begin
            acc     <= {{WIDTH{1'b0}}, absA};
            operand <= absB;
            state   <= RUN;
          end else begin
            acc     <= {{WIDTH{1'b0}}, absB};
            operand <= absA;
            state   <= RUN;
          end
        end

        RUN: begin
          acc <= accStep;
          cnt <= cnt + CntW'(1);
          if (cnt == CntW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end

        FIX: begin
          if (isDivide(opReg)) begin
            hi <= remFixed;
            lo <= quoFixed;
          end else begin
            hi <= prodFixed[2*WIDTH-1:WIDTH];
            lo <= prodFixed[WIDTH-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
